// File: rtl/jsi_exec_core_if.sv
// Request/response bundle for jsi_exec_core: operand handshake, result and serial line.
interface jsi_exec_core_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [2:0]            opcode;
  logic [2*DATA_W-1:0]   result;
  logic                  result_valid;
  logic                  busy;
  logic                  tx;

  modport master (
    output in_valid, op_a, op_b, opcode,
    input  in_ready, result, result_valid, busy, tx
  );

  modport slave (
    input  in_valid, op_a, op_b, opcode,
    output in_ready, result, result_valid, busy, tx
  );
endinterface

// File: rtl/jsi_exec_core.sv
// Single-shot ALU that computes one 2*DATA_W result per request and streams it
// out LSB-byte-first as back-to-back UART 8N1 frames.
module jsi_exec_core #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  jsi_exec_core_if.slave  bus
);
  localparam int RW     = 2 * DATA_W;
  localparam int NBYTES = (RW + 7) / 8;
  localparam int FW     = NBYTES * 8;
  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0]  CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_STOP  = 3'd4
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [2:0]        op_reg;
  logic [RW-1:0]     result_reg;
  logic              result_valid_reg;
  logic              busy_reg;
  logic              in_ready_reg;
  logic              tx_reg;
  logic [CW-1:0]     clk_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [BCW-1:0]    byte_cnt_reg;
  logic [FW-1:0]     shift_reg;

  logic [RW-1:0]     a_ext;
  logic [RW-1:0]     b_ext;
  logic [RW-1:0]     alu_next;
  logic              bit_end;

  assign bit_end = (clk_cnt_reg == CLK_LAST);

  always_comb begin
    a_ext    = RW'(a_reg);
    b_ext    = RW'(b_reg);
    alu_next = '0;
    case (op_reg)
      3'd0: alu_next = a_ext + b_ext;
      3'd1: alu_next = a_ext - b_ext;
      3'd2: alu_next = a_ext * b_ext;
      3'd3: alu_next = a_ext & b_ext;
      3'd4: alu_next = a_ext | b_ext;
      3'd5: alu_next = a_ext ^ b_ext;
      3'd6: alu_next = a_ext << b_reg[3:0];
      default: alu_next[2:0] = {a_reg > b_reg, a_reg == b_reg, a_reg < b_reg};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      a_reg            <= '0;
      b_reg            <= '0;
      op_reg           <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      in_ready_reg     <= 1'b1;
      tx_reg           <= 1'b1;
      clk_cnt_reg      <= '0;
      bit_cnt_reg      <= '0;
      byte_cnt_reg     <= '0;
      shift_reg        <= '0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.op_a;
            b_reg        <= bus.op_b;
            op_reg       <= bus.opcode;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          result_reg       <= alu_next;
          result_valid_reg <= 1'b1;
          shift_reg        <= FW'(alu_next);
          clk_cnt_reg      <= '0;
          bit_cnt_reg      <= '0;
          byte_cnt_reg     <= '0;
          tx_reg           <= 1'b0;
          state_reg        <= TX_START;
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
            state_reg   <= TX_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt_reg <= '0;
            // Shifting per bit leaves the next byte aligned at bit 0 after 8 bits.
            shift_reg   <= shift_reg >> 1;
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_reg <= '0;
              tx_reg      <= 1'b1;
              state_reg   <= TX_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            clk_cnt_reg <= '0;
            if (byte_cnt_reg == BYTE_LAST) begin
              byte_cnt_reg <= '0;
              busy_reg     <= 1'b0;
              in_ready_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + BCW'(1);
              tx_reg       <= 1'b0;
              state_reg    <= TX_START;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        default: begin
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
          tx_reg       <= 1'b1;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.tx           = tx_reg;
endmodule

// File: tb/tb_jsi_exec_core.sv
// Directed bench for jsi_exec_core: an 8-bit core and a 4-bit core, both with
// 4 clocks per UART bit, checked against hand-computed results and frames.
module tb_jsi_exec_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jsi_exec_core_if #(.DATA_W(8)) bus ();
  jsi_exec_core_if #(.DATA_W(4)) nbus ();

  jsi_exec_core #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  jsi_exec_core #(.DATA_W(4), .CLKS_PER_BIT(4)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nbus)
  );

  int errors = 0;
  int checks = 0;

  logic tx_s   [0:79];
  logic busy_s [0:79];
  logic rv_s   [0:79];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%b, required 1 within 300 cycles", bus.in_ready);
    end
  endtask

  // One request through the 8-bit core; hold=1 keeps in_valid high with
  // scrambled operands for the whole transmission.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [15:0] exp, input bit hold);
    int pulses;
    int bad_busy;
    int bad_bits;
    logic [9:0] frame;
    wait_ready();
    bus.op_a     = a;
    bus.op_b     = b;
    bus.opcode   = op;
    bus.in_valid = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: busy=%b in_ready=%b, required busy=1 in_ready=0",
               name, bus.busy, bus.in_ready);
    end
    if (!hold) bus.in_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (hold) begin
        bus.op_a   = 8'($urandom_range(0, 255));
        bus.op_b   = 8'($urandom_range(0, 255));
        bus.opcode = 3'($urandom_range(0, 7));
      end
      step();
      tx_s[i]   = bus.tx;
      busy_s[i] = bus.busy;
      rv_s[i]   = bus.result_valid;
      if (i == 0) begin
        checks++;
        if (bus.result !== exp || bus.result_valid !== 1'b1 || bus.tx !== 1'b0) begin
          errors++;
          $display("FAIL %s result: result=%h rv=%b tx=%b, required result=%h rv=1 tx=0",
                   name, bus.result, bus.result_valid, bus.tx, exp);
        end
      end
    end
    pulses = 0;
    bad_busy = 0;
    for (int i = 0; i < 80; i++) begin
      if (rv_s[i] === 1'b1) pulses++;
      if (busy_s[i] !== 1'b1) bad_busy++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL %s rv_pulse: result_valid high %0d cycles, required 1", name, pulses);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy: busy low in %0d of 80 tx cycles, required 0", name, bad_busy);
    end
    for (int j = 0; j < 2; j++) begin
      frame = {1'b1, exp[j*8 +: 8], 1'b0};
      bad_bits = 0;
      for (int m = 0; m < 10; m++)
        for (int k = 0; k < 4; k++)
          if (tx_s[(j*10 + m)*4 + k] !== frame[m]) bad_bits++;
      checks++;
      if (bad_bits != 0) begin
        errors++;
        $display("FAIL %s frame%0d: %0d tx samples wrong, required byte %h", name, j, bad_bits,
                 exp[j*8 +: 8]);
      end
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s early_ready: in_ready=%b at T+80, required 0", name, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx !== 1'b1 || bus.result !== exp) begin
      errors++;
      $display("FAIL %s done: in_ready=%b busy=%b tx=%b result=%h, required 1 0 1 %h",
               name, bus.in_ready, bus.busy, bus.tx, bus.result, exp);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s extra_transfer: busy=%b after completion, required 0", name, bus.busy);
    end
    $display("op %s a=%h b=%h opcode=%0d expected=%h", name, a, b, op, exp);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.op_a      = 8'h01;
    bus.op_b      = 8'h01;
    bus.opcode    = 3'd0;
    nbus.in_valid = 1'b0;
    nbus.op_a     = '0;
    nbus.op_b     = '0;
    nbus.opcode   = '0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx !== 1'b1 ||
        bus.result !== 16'h0000 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b busy=%b tx=%b result=%h rv=%b, required 1 0 1 0000 0",
               bus.in_ready, bus.busy, bus.tx, bus.result, bus.result_valid);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || nbus.busy !== 1'b0 || nbus.tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: busy=%b nbusy=%b ntx=%b, required 0 0 1",
               bus.busy, nbus.busy, nbus.tx);
    end
    $display("reset released");
  endtask

  task automatic test_ops();
    run_op("ADD",  8'hFF, 8'h01, 3'd0, 16'h0100, 1'b0);
    run_op("SUB",  8'h03, 8'h05, 3'd1, 16'hFFFE, 1'b0);
    run_op("MUL",  8'hFF, 8'hFF, 3'd2, 16'hFE01, 1'b0);
    run_op("AND",  8'hF0, 8'h3C, 3'd3, 16'h0030, 1'b0);
    run_op("OR",   8'hF0, 8'h0F, 3'd4, 16'h00FF, 1'b0);
    run_op("XOR",  8'hAA, 8'hFF, 3'd5, 16'h0055, 1'b0);
    run_op("SHL",  8'h81, 8'h04, 3'd6, 16'h0810, 1'b0);
    run_op("CMPEQ", 8'h10, 8'h10, 3'd7, 16'h0002, 1'b0);
    run_op("CMPGT", 8'h20, 8'h10, 3'd7, 16'h0004, 1'b0);
    run_op("CMPLT", 8'h01, 8'h02, 3'd7, 16'h0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("HOLD", 8'h12, 8'h34, 3'd0, 16'h0046, 1'b1);
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    wait_ready();
    bus.op_a     = 8'hFF;
    bus.op_b     = 8'hFF;
    bus.opcode   = 3'd2;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 22; i++) step();
    // Sample 21 lies inside data bit 4 of byte 0x01, which is a 0.
    checks++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b busy=%b, required 0 1", bus.tx, bus.busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.result !== 16'h0000 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: tx=%b busy=%b in_ready=%b result=%h rv=%b, required 1 0 1 0000 0",
               bus.tx, bus.busy, bus.in_ready, bus.result, bus.result_valid);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d cycles not idle after reset, required 0", bad);
    end
    $display("mid-frame reset applied");
    run_op("POSTRST", 8'h03, 8'h05, 3'd1, 16'hFFFE, 1'b0);
  endtask

  task automatic test_narrow();
    int bad_bits = 0;
    int bad_busy = 0;
    logic [9:0] frame;
    logic [7:0] exp_n;
    exp_n = 8'hE1;
    frame = {1'b1, exp_n, 1'b0};
    nbus.op_a     = 4'hF;
    nbus.op_b     = 4'hF;
    nbus.opcode   = 3'd2;
    nbus.in_valid = 1'b1;
    step();
    nbus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (nbus.result !== exp_n || nbus.result_valid !== 1'b1) begin
          errors++;
          $display("FAIL narrow_result: result=%h rv=%b, required e1 1", nbus.result,
                   nbus.result_valid);
        end
      end
      if (nbus.tx !== frame[i/4]) bad_bits++;
      if (nbus.busy !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_bits != 0 || bad_busy != 0) begin
      errors++;
      $display("FAIL narrow_frame: %0d bad tx samples, %0d busy gaps, required 0 0",
               bad_bits, bad_busy);
    end
    step();
    checks++;
    if (nbus.busy !== 1'b0 || nbus.in_ready !== 1'b1 || nbus.tx !== 1'b1) begin
      errors++;
      $display("FAIL narrow_done: busy=%b in_ready=%b tx=%b, required 0 1 1",
               nbus.busy, nbus.in_ready, nbus.tx);
    end
    $display("op NARROW_MUL a=f b=f expected=e1");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.opcode   = '0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_mid_reset();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jsi_exec_core.md
JSI_EXEC_CORE -- requirements
Module: jsi_exec_core

Interface
REQ-001 Parameter DATA_W, default 8: operand width in bits; legal values are 4 to 16.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal values are 2 or more.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low, sampled on the clk rising edge.
REQ-005 in_valid  input  1  operand and opcode presented this cycle.
REQ-006 in_ready  output  1  core can accept a request this cycle.
REQ-007 op_a  input  DATA_W  operand A, unsigned.
REQ-008 op_b  input  DATA_W  operand B, unsigned.
REQ-009 opcode  input  3  operation select.
REQ-010 result  output  2*DATA_W  registered result of the last completed operation.
REQ-011 result_valid  output  1  one-cycle pulse when result updates.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tx  output  1  UART 8N1 serial output; idle level is high.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, TX_START, TX_DATA, TX_STOP.
REQ-015 in_ready SHALL equal 1 only in IDLE; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-016 On a transfer, the core SHALL capture op_a, op_b and opcode and go IDLE->EXEC; in_valid outside IDLE is ignored and nothing is queued.
REQ-017 Operands SHALL be zero-extended to 2*DATA_W, and all results SHALL wrap modulo 2^(2*DATA_W).
REQ-018 Opcodes: 000 ADD a+b; 001 SUB a-b (two's complement); 010 MUL a*b; 011 AND; 100 OR; 101 XOR; 110 SHL a<<b[3:0]; 111 CMP, giving {..0, a>b, a==b, a<b} in bits [2:0].
REQ-019 EXEC SHALL last one cycle: on the EXEC->TX_START edge, result loads and result_valid is 1 for exactly the following cycle.
REQ-020 result SHALL hold its value until the next EXEC completes.
REQ-021 The core SHALL transmit NBYTES = ceil(2*DATA_W/8) bytes, least-significant byte first; unused upper bits of the last byte are 0.
REQ-022 Each byte SHALL be sent as a frame of one start bit (0), 8 data bits LSB first, and one stop bit (1), with each bit held for exactly CLKS_PER_BIT cycles.
REQ-023 The frames of consecutive bytes SHALL be back-to-back: TX_STOP goes to TX_START while bytes remain, otherwise to IDLE.
REQ-024 tx SHALL go low in the same cycle result_valid is high, which is 2 cycles after the transfer edge.
REQ-025 Total busy time SHALL be 1 + NBYTES*10*CLKS_PER_BIT cycles, after which in_ready rises.
REQ-026 The bit-cycle counter and the bit counter SHALL wrap to 0 at each bit boundary and frame boundary with no idle gap cycle.

Reset
REQ-027 While rst_n=0 at a clk edge, the state SHALL become IDLE, tx=1, result=0, result_valid=0, busy=0, in_ready=1, and all counters 0.
REQ-028 Reset asserted mid-frame SHALL abort transmission with tx=1 from the next cycle, with no partial-byte completion.
REQ-029 A transfer attempted on the same edge that rst_n=0 SHALL be discarded.

Verification (DATA_W=8, CLKS_PER_BIT=4, so NBYTES=2 and 80 tx cycles)
REQ-030 ADD a=0xFF, b=0x01 -> result=0x0100 with result_valid one cycle at T+2; tx sends 0x00 then 0x01; in_ready returns at T+82.
REQ-031 SUB a=0x03, b=0x05 -> result=0xFFFE; bytes 0xFE then 0xFF; MUL a=0xFF, b=0xFF -> result=0xFE01.
REQ-032 CMP a=0x10, b=0x10 -> result=0x0002; SHL a=0x81, b=0x04 -> result=0x0810.
REQ-033 in_valid held high throughout a transmission with changing operands -> exactly one transfer occurs; result and frames match the operands captured at the first transfer.
REQ-034 rst_n=0 for one cycle during the fifth data bit of byte 0 -> tx=1, busy=0, in_ready=1, result=0x0000 on the next cycle; a new request then completes normally.
REQ-035 DATA_W=4 build: MUL a=0xF, b=0xF -> result=0xE1, NBYTES=1, one frame of 0xE1, busy time 41 cycles.
